sdram_arbiter: RTL and testbench

Central command scheduler for the SDRAM controller. It sits between the `sdram_init`, `sdram_aref`, `sdram_write` and `sdram_read` sub-modules and the SDRAM pins. Once initialisation finishes, it grants the shared command/address/data bus to one sub-module at a time, using these rules:
- auto-refresh has highest priority;
- write and read alternate when both are pending.

The grant is routed to the pins with a registered state and a combinational output mux.

---
 rtl/sdram_arbiter.sv | 140 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the shared SDRAM command/address/data bus to init, refresh, write or read.
// Latency: request seen in ARBIT at edge N gives a grant from N+1; each owner change passes through one NOP cycle.
// Backpressure: requests are held until granted; refresh wins, write/read alternate, bursts are never preempted.
module sdram_arbiter #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  write_cmd,
    input  logic [1:0]  write_ba,
    input  logic [12:0] write_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  read_cmd,
    input  logic [1:0]  read_ba,
    input  logic [12:0] read_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        sdram_cke,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t state;
    logic   last_was_wr;

    // Grants are registered alongside the state so they always equal the state decode.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= INIT;
            last_was_wr <= 1'b0;
            aref_en     <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_end) state <= ARBIT;
                end
                ARBIT: begin
                    if (aref_req) begin
                        state   <= AREF;
                        aref_en <= 1'b1;
                    end else if (wr_req && (!rd_req || !last_was_wr)) begin
                        state       <= WRITE;
                        wr_en       <= 1'b1;
                        last_was_wr <= 1'b1;
                    end else if (rd_req) begin
                        state       <= READ;
                        rd_en       <= 1'b1;
                        last_was_wr <= 1'b0;
                    end
                end
                AREF: begin
                    if (aref_end) begin
                        state   <= ARBIT;
                        aref_en <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_end) begin
                        state <= ARBIT;
                        wr_en <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_end) begin
                        state <= ARBIT;
                        rd_en <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARBIT;
                    aref_en <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1FFF;
        case (state)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                sdram_cmd  = write_cmd;
                sdram_ba   = write_ba;
                sdram_addr = write_addr;
            end
            READ: begin
                sdram_cmd  = read_cmd;
                sdram_ba   = read_ba;
                sdram_addr = read_addr;
            end
            default: ;
        endcase
    end

    assign sdram_cke    = 1'b1;
    assign sdram_dq_out = wr_sdram_data;
    assign sdram_dq_oe  = wr_sdram_en && (state == WRITE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, init handoff, grant timing, alternation, refresh priority.
module tb_sdram_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        init_end = 1'b0;
    logic [3:0]  init_cmd = 4'h1;
    logic [1:0]  init_ba = 2'b00;
    logic [12:0] init_addr = 13'h0101;
    logic        aref_req = 1'b0;
    logic        aref_end = 1'b0;
    logic [3:0]  aref_cmd = 4'h2;
    logic [1:0]  aref_ba = 2'b01;
    logic [12:0] aref_addr = 13'h0202;
    logic        wr_req = 1'b0;
    logic        wr_end = 1'b0;
    logic [3:0]  write_cmd = 4'h3;
    logic [1:0]  write_ba = 2'b10;
    logic [12:0] write_addr = 13'h0303;
    logic        wr_sdram_en = 1'b1;
    logic [15:0] wr_sdram_data = 16'hA5C3;
    logic        rd_req = 1'b0;
    logic        rd_end = 1'b0;
    logic [3:0]  read_cmd = 4'h4;
    logic [1:0]  read_ba = 2'b00;
    logic [12:0] read_addr = 13'h0404;
    logic        aref_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic        sdram_cke;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    int total = 0;
    int bad = 0;

    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_AREF = 3'b100;
    localparam logic [2:0] G_WR   = 3'b010;
    localparam logic [2:0] G_RD   = 3'b001;

    sdram_arbiter dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .write_cmd(write_cmd), .write_ba(write_ba), .write_addr(write_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .read_cmd(read_cmd), .read_ba(read_ba), .read_addr(read_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_cke(sdram_cke),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [2:0] grants();
        return {aref_en, wr_en, rd_en};
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        sys_rst = 1'b0;
        chk("rst_grants", grants(), G_NONE);
        chk("rst_cmd", sdram_cmd, 4'h1);
        chk("rst_ba", sdram_ba, 2'b00);
        chk("rst_addr", sdram_addr, 13'h0101);
        chk("rst_dq_oe", sdram_dq_oe, 1'b0);
        chk("rst_cke", sdram_cke, 1'b1);
        chk("dq_out", sdram_dq_out, 16'hA5C3);

        // Requests are not granted while in INIT
        wr_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("init_cmd_hold", sdram_cmd, 4'h1);
            chk("init_no_grant", grants(), G_NONE);
        end
        wr_req = 1'b0;
        init_end = 1'b1;
        tick();
        init_end = 1'b0;
        chk("nop_cmd", sdram_cmd, 4'b0111);
        chk("nop_ba", sdram_ba, 2'b11);
        chk("nop_addr", sdram_addr, 13'h1FFF);
        chk("nop_grants", grants(), G_NONE);
        chk("nop_dq_oe", sdram_dq_oe, 1'b0);

        // Single write, spurious rd_end, DQ enable gating
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("wr_grant", grants(), G_WR);
        chk("wr_cmd", sdram_cmd, 4'h3);
        chk("wr_addr", sdram_addr, 13'h0303);
        chk("wr_dq_oe_on", sdram_dq_oe, 1'b1);
        wr_sdram_en = 1'b0;
        #1;
        chk("wr_dq_oe_off", sdram_dq_oe, 1'b0);
        wr_sdram_en = 1'b1;
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        chk("spurious_rd_end", grants(), G_WR);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        chk("wr_end_drop", grants(), G_NONE);
        chk("wr_end_nop", sdram_cmd, 4'b0111);

        // Reset in the middle of a write
        wr_req = 1'b1;
        tick();
        chk("wr2_grant", grants(), G_WR);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("midrst_grants", grants(), G_NONE);
        chk("midrst_dq_oe", sdram_dq_oe, 1'b0);
        chk("midrst_cmd", sdram_cmd, 4'h1);
        chk("midrst_addr", sdram_addr, 13'h0101);

        // Alternation with both requests held: last_was_wr cleared by reset, so W,R,W,R
        rd_req = 1'b1;
        init_end = 1'b1;
        tick();
        init_end = 1'b0;
        chk("alt_start_nop", sdram_cmd, 4'b0111);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("alt_grant", grants(), (k % 2 == 0) ? G_WR : G_RD);
            repeat (19) tick();
            chk("alt_hold", grants(), (k % 2 == 0) ? G_WR : G_RD);
            if (k % 2 == 0) wr_end = 1'b1; else rd_end = 1'b1;
            tick();
            wr_end = 1'b0;
            rd_end = 1'b0;
            chk("alt_bubble_grants", grants(), G_NONE);
            chk("alt_bubble_cmd", sdram_cmd, 4'b0111);
        end

        // Refresh arriving mid-read waits for rd_end; then write beats pending read
        wr_req = 1'b0;
        tick();
        chk("rd_grant", grants(), G_RD);
        chk("rd_cmd", sdram_cmd, 4'h4);
        repeat (5) tick();
        aref_req = 1'b1;
        wr_req = 1'b1;
        repeat (3) tick();
        chk("rd_no_preempt", grants(), G_RD);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        chk("pre_aref_nop", grants(), G_NONE);
        tick();
        aref_req = 1'b0;
        chk("aref_grant", grants(), G_AREF);
        chk("aref_cmd", sdram_cmd, 4'h2);
        chk("aref_ba", sdram_ba, 2'b01);
        repeat (4) tick();
        chk("aref_hold", grants(), G_AREF);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        chk("post_aref_nop", grants(), G_NONE);
        tick();
        chk("wr_after_rd", grants(), G_WR);
        wr_req = 1'b0;
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        chk("final_nop", grants(), G_NONE);
        tick();
        chk("rd_after_wr", grants(), G_RD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
